// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI-mode SD command engine between requesters.
// Grants, launches the command, waits for R1 with timeout, and supports locked multi-command sequences.
module sd_cmd_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TW      = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [6*NREQ-1:0]  cmd_in,
    input  logic [32*NREQ-1:0] arg_in,
    input  logic [7*NREQ-1:0]  crc_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [7:0]         resp,
    output logic               timeout,
    output logic               eng_start,
    output logic [5:0]         eng_cmd,
    output logic [31:0]        eng_arg,
    output logic [6:0]         eng_crc,
    input  logic               eng_busy,
    input  logic               eng_done,
    input  logic [7:0]         eng_resp
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  cur;
    logic [TW-1:0]  cnt;
    logic [PW-1:0]  win;
    logic           win_vld;
    logic [PW-1:0]  cur_next;
    int unsigned    scan_idx;

    // Round-robin scan starting at ptr, wrapping at NREQ
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(ptr) + k) % NREQ;
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win     = PW'(scan_idx);
            end
        end
    end

    assign cur_next  = (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
    assign eng_start = (state == ISSUE) && !eng_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            ack     <= '0;
            resp    <= 8'hFF;
            timeout <= 1'b0;
            eng_cmd <= '0;
            eng_arg <= '0;
            eng_crc <= '0;
        end else begin
            ack     <= '0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cur     <= win;
                        gnt     <= NREQ'(1) << win;
                        eng_cmd <= cmd_in[32'(win)*6 +: 6];
                        eng_arg <= arg_in[32'(win)*32 +: 32];
                        eng_crc <= crc_in[32'(win)*7 +: 7];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_start) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Abort lands ack exactly TIMEOUT cycles after the launch cycle
                    if (eng_done) begin
                        resp  <= eng_resp;
                        ack   <= gnt;
                        state <= DONE;
                    end else if (cnt == TW'(TIMEOUT - 2)) begin
                        resp    <= 8'hFF;
                        timeout <= 1'b1;
                        ack     <= gnt;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (lock[cur]) begin
                        state <= HOLD;
                    end else begin
                        gnt   <= '0;
                        ptr   <= cur_next;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (req[cur]) begin
                        eng_cmd <= cmd_in[32'(cur)*6 +: 6];
                        eng_arg <= arg_in[32'(cur)*32 +: 32];
                        eng_crc <= crc_in[32'(cur)*7 +: 7];
                        state   <= ISSUE;
                    end else if (!lock[cur]) begin
                        gnt   <= '0;
                        ptr   <= cur_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed self-checking bench for sd_cmd_arbiter with TIMEOUT=16.
module tb_sd_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, lock;
    logic [17:0] cmd_in;
    logic [95:0] arg_in;
    logic [20:0] crc_in;
    logic [2:0]  gnt, ack;
    logic [7:0]  resp;
    logic        timeout, eng_start;
    logic [5:0]  eng_cmd;
    logic [31:0] eng_arg;
    logic [6:0]  eng_crc;
    logic        eng_busy, eng_done;
    logic [7:0]  eng_resp;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int starts_before;

    sd_cmd_arbiter #(.NREQ(3), .TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .cmd_in(cmd_in), .arg_in(arg_in), .crc_in(crc_in),
        .gnt(gnt), .ack(ack), .resp(resp), .timeout(timeout),
        .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_arg(eng_arg), .eng_crc(eng_crc),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_resp(eng_resp)
    );

    always #5 clk = ~clk;

    // Grant must never be more than one-hot; count launches
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                errors++;
                $error("FAIL gnt_onehot observed=%b expected=onehot0", gnt);
            end
        end
        if (eng_start) starts++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; cmd_in = '0; arg_in = '0; crc_in = '0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_resp = '0;
        step(2);
        rst = 1'b0;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_resp", 64'(resp), 64'hFF);
        chk("rst_timeout", 64'(timeout), 64'h0);
        chk("rst_start", 64'(eng_start), 64'h0);
        chk("rst_cmd", 64'(eng_cmd), 64'h0);

        // Single request from requester 0
        req = 3'b001; crc_in[6:0] = 7'h4A;
        step(1);
        chk("single_gnt", 64'(gnt), 64'h1);
        chk("single_crc", 64'(eng_crc), 64'h4A);
        chk("single_start", 64'(eng_start), 64'h1);
        step(5);
        eng_done = 1'b1; eng_resp = 8'h01;
        step(1);
        chk("single_ack", 64'(ack), 64'h1);
        chk("single_resp", 64'(resp), 64'h01);
        chk("single_to", 64'(timeout), 64'h0);
        eng_done = 1'b0; req = '0;
        step(1);
        chk("single_rel_gnt", 64'(gnt), 64'h0);
        chk("single_ack_pulse", 64'(ack), 64'h0);

        // Contention: all three requesting, ptr restarted by reset
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < 3; i++) cmd_in[6*i +: 6] = 6'(i + 1);
        req = 3'b111;
        starts_before = starts;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = k % 3;
            step(1);
            chk("cont_gnt", 64'(gnt), 64'(3'b001 << w));
            chk("cont_cmd", 64'(eng_cmd), 64'(w + 1));
            step(1);
            eng_done = 1'b1; eng_resp = 8'(8'h10 + w);
            step(1);
            chk("cont_ack", 64'(ack), 64'(3'b001 << w));
            chk("cont_resp", 64'(resp), 64'(8'h10 + w));
            eng_done = 1'b0;
            step(1);
            chk("cont_idle_gnt", 64'(gnt), 64'h0);
        end
        req = '0;
        chk("cont_starts", 64'(starts - starts_before), 64'd4);

        // Lock: requester 0 does CMD55 then ACMD41 while requester 1 waits
        req = 3'b001; lock = 3'b001; cmd_in[5:0] = 6'd55; cmd_in[11:6] = 6'd17;
        step(1);
        chk("lock_gnt55", 64'(gnt), 64'h1);
        chk("lock_cmd55", 64'(eng_cmd), 64'd55);
        req = 3'b011;
        step(1);
        eng_done = 1'b1; eng_resp = 8'h01;
        step(1);
        chk("lock_ack55", 64'(ack), 64'h1);
        eng_done = 1'b0; cmd_in[5:0] = 6'd41;
        step(1);
        chk("lock_hold_gnt", 64'(gnt), 64'h1);
        step(1);
        chk("lock_gnt41", 64'(gnt), 64'h1);
        chk("lock_cmd41", 64'(eng_cmd), 64'd41);
        chk("lock_start41", 64'(eng_start), 64'h1);
        req = 3'b010;
        step(1);
        eng_done = 1'b1; eng_resp = 8'h00;
        step(1);
        chk("lock_ack41", 64'(ack), 64'h1);
        chk("lock_resp41", 64'(resp), 64'h00);
        eng_done = 1'b0;
        step(2);
        chk("lock_still_held", 64'(gnt), 64'h1);
        lock = 3'b000;
        step(1);
        chk("lock_release", 64'(gnt), 64'h0);
        step(1);
        chk("lock_gnt_req1", 64'(gnt), 64'h2);
        chk("lock_cmd_req1", 64'(eng_cmd), 64'd17);
        step(1);
        eng_done = 1'b1; eng_resp = 8'h05;
        step(1);
        chk("lock_ack_req1", 64'(ack), 64'h2);
        eng_done = 1'b0; req = '0;
        step(1);

        // Timeout on requester 2: ack exactly 16 cycles after launch
        req = 3'b100; cmd_in[17:12] = 6'd24;
        step(1);
        chk("to_gnt", 64'(gnt), 64'h4);
        chk("to_start", 64'(eng_start), 64'h1);
        step(15);
        chk("to_ack_early", 64'(ack), 64'h0);
        step(1);
        chk("to_ack", 64'(ack), 64'h4);
        chk("to_resp", 64'(resp), 64'hFF);
        chk("to_flag", 64'(timeout), 64'h1);
        req = '0;
        step(1);
        chk("to_release", 64'(gnt), 64'h0);
        chk("to_flag_clear", 64'(timeout), 64'h0);

        // Busy engine delays launch 3 cycles; eng_done on last WAIT cycle wins
        eng_busy = 1'b1; req = 3'b001;
        step(1);
        chk("busy_start0", 64'(eng_start), 64'h0);
        step(1);
        chk("busy_start1", 64'(eng_start), 64'h0);
        step(1);
        chk("busy_start2", 64'(eng_start), 64'h0);
        eng_busy = 1'b0;
        #1;
        chk("busy_start3", 64'(eng_start), 64'h1);
        step(15);
        eng_done = 1'b1; eng_resp = 8'h5A;
        step(1);
        chk("edge_ack", 64'(ack), 64'h1);
        chk("edge_to", 64'(timeout), 64'h0);
        chk("edge_resp", 64'(resp), 64'h5A);
        eng_done = 1'b0; req = '0;
        step(1);

        // Reset in the middle of WAIT for requester 1
        req = 3'b010;
        step(3);
        chk("rstw_gnt_pre", 64'(gnt), 64'h2);
        req = '0; rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rstw_gnt", 64'(gnt), 64'h0);
        chk("rstw_resp", 64'(resp), 64'hFF);
        chk("rstw_ack", 64'(ack), 64'h0);
        step(2);
        chk("rstw_ack_later", 64'(ack), 64'h0);
        req = 3'b011;
        step(1);
        chk("rstw_ptr0", 64'(gnt), 64'h1);
        req = 3'b000;
        step(1);
        eng_done = 1'b1; eng_resp = 8'h00;
        step(1);
        chk("rstw_ack_final", 64'(ack), 64'h1);
        eng_done = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
